// File: rtl/uart_word_serializer.sv
// uart_word_serializer: buffers N-byte words in a small FIFO and feeds
// them byte by byte to a UART TX core over a level start/done handshake.
//
// Optional feature macro: UART_WORD_SER_CKSUM_EN
//   defined   -> one extra byte per word, the XOR of its data bytes
//   undefined -> exactly WORD_BYTES bytes per word, no checksum logic
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   data_in      word to send (8*WORD_BYTES bits)
//   in_valid     data_in valid; accepted when in_ready is high
//   in_ready     FIFO not full
//   abort        synchronous flush of FIFO and the word in flight
//   tx_done      UART idle/finished (high = idle)
//   tx_data      byte to UART, stable while tx_start is high
//   tx_start     send request to UART
//   busy         FSM not idle or FIFO not empty
//   level        FIFO occupancy
//   words_sent   completed words, wraps
//   err_timeout  sticky handshake timeout flag, cleared by rst or abort
module uart_word_serializer #(
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int MSB_FIRST   = 1,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*WORD_BYTES-1:0]       data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          abort,
    input  logic                          tx_done,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [15:0]                   words_sent,
    output logic                          err_timeout
);

    localparam int DW  = 8 * WORD_BYTES;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES - 1);
    localparam logic [LW-1:0]  FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0]  TMAX      =
        TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT
    } state_t;

    // Byte at the transmit end of a word, and the word advanced by one byte
    function automatic logic [7:0] first_byte(input logic [DW-1:0] w);
        if (MSB_FIRST != 0) return w[DW-1 -: 8];
        else                return w[7:0];
    endfunction

    function automatic logic [DW-1:0] shift_word(input logic [DW-1:0] w);
        if (MSB_FIRST != 0) return w << 8;
        else                return w >> 8;
    endfunction

    state_t state_q, state_d;

    logic [DW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [DW-1:0]  sh_q, sh_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic [15:0]    words_q, words_d;
    logic           err_q, err_d;
`ifdef UART_WORD_SER_CKSUM_EN
    logic [7:0]     cks_q, cks_d;
    logic           cks_phase_q, cks_phase_d;
`endif

    logic push;
    logic pop;
    logic last_byte;
    logic word_done;
    logic timeout_hit;
    logic [DW-1:0] sh_next;

    // in_ready looks only at full: a same-cycle pop does not free a slot
    assign in_ready    = (level_q != FULL_LVL);
    assign busy        = (state_q != S_IDLE) || (level_q != '0);
    assign push        = in_valid && in_ready && !abort;
    assign pop         = (state_q == S_LOAD) && !abort;
    assign last_byte   = (byte_cnt_q == LAST_BYTE);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (timer_q == TMAX);
    assign sh_next     = shift_word(sh_q);

`ifdef UART_WORD_SER_CKSUM_EN
    // The word ends only once its checksum byte has been handed over
    assign word_done = cks_phase_q;
`else
    assign word_done = last_byte;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (level_q != '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: begin
                if (!tx_done)        state_d = S_WAIT;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_WAIT:  if (tx_done) state_d = S_NEXT;
            S_NEXT: begin
                if (word_done)
                    state_d = (level_q != '0) ? S_LOAD : S_IDLE;
                else
                    state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // FSM outputs and datapath
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        sh_d       = sh_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = '0;
        tx_data_d  = tx_data_q;
        words_d    = words_q;
        err_d      = err_q;
`ifdef UART_WORD_SER_CKSUM_EN
        cks_d       = cks_q;
        cks_phase_d = cks_phase_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                sh_d       = mem_q[rd_ptr_q];
                byte_cnt_d = '0;
                tx_data_d  = first_byte(mem_q[rd_ptr_q]);
`ifdef UART_WORD_SER_CKSUM_EN
                cks_d       = 8'h00;
                cks_phase_d = 1'b0;
`endif
            end
            S_START: begin
                // timer restarts from zero on every START entry
                if (tx_done && timeout_hit) err_d = 1'b1;
                else if (tx_done)           timer_d = timer_q + 1'b1;
            end
            S_NEXT: begin
`ifdef UART_WORD_SER_CKSUM_EN
                cks_d = cks_q ^ first_byte(sh_q);
`endif
                if (word_done) begin
                    words_d = words_q + 16'd1;
                end
`ifdef UART_WORD_SER_CKSUM_EN
                else if (last_byte) begin
                    cks_phase_d = 1'b1;
                    tx_data_d   = cks_q ^ first_byte(sh_q);
                end
`endif
                else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    sh_d       = sh_next;
                    tx_data_d  = first_byte(sh_next);
                end
            end
            default: ;
        endcase
        tx_start_d = (state_d == S_START);
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            sh_q        <= '0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            words_q     <= 16'h0000;
            err_q       <= 1'b0;
`ifdef UART_WORD_SER_CKSUM_EN
            cks_q       <= 8'h00;
            cks_phase_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sh_q        <= sh_d;
            byte_cnt_q  <= byte_cnt_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            words_q     <= words_d;
            err_q       <= err_d;
`ifdef UART_WORD_SER_CKSUM_EN
            cks_q       <= cks_d;
            cks_phase_q <= cks_phase_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign level       = level_q;
    assign words_sent  = words_q;
    assign err_timeout = err_q;

endmodule
